// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage.
// - Bus widths for the EX->MEM and MEM->WB pipeline buses.
// - ld_type encodings used by exe_stage and the load extender.
// - Exception codes. ex_code is {esubcode[8:0], ecode[5:0]}.
// - Packed layouts of both buses. The first member is the MSB.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 206;
  localparam int MS_TO_WS_BUS_WD = 232;

  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_H  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;

  localparam logic [14:0] EXC_ALE = {9'd0, ECODE_ALE};

  // EX->MEM payload, 206 bits.
  // es_spare holds trailing bits that exe_stage packs for its own use.
  // MEM ignores them.
  typedef struct packed {
    logic        res_from_mem;
    logic [2:0]  ld_type;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic        inst_no_dest;
    logic        src_from_csr;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic [31:0] csr_wmask;
    logic        ex;
    logic [14:0] ex_code;
    logic        ertn;
    logic [31:0] csr_rdata;
    logic [1:0]  es_spare;
  } es_bus_t;

  // MEM->WB payload, 232 bits.
  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
    logic        inst_no_dest;
    logic        src_from_csr;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic [31:0] csr_wmask;
    logic        ex;
    logic [14:0] ex_code;
    logic        ertn;
    logic [31:0] csr_rdata;
    logic [31:0] vaddr;
  } ms_bus_t;

endpackage

// File: rtl/mem_stage_load_extend.sv
// Combinational load extender.
// Picks the byte or half selected by addr_lo out of a 32-bit read word,
// then sign- or zero-extends it according to ld_type.
// Ports:
//   ld_type  in   3   load kind (LD_* codes)
//   addr_lo  in   2   vaddr[1:0], byte lane
//   word     in  32   raw SRAM word
//   value    out 32   aligned/extended load result (0 for unknown codes)
module mem_stage_load_extend
  import mem_stage_pkg::*;
(
  input  logic [2:0]  ld_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] value
);

  logic        [7:0]  byte_sel;
  logic        [15:0] half_sel;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] byte_sx;
  logic signed [31:0] half_sx;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    byte_s  = signed'(byte_sel);
    half_s  = signed'(half_sel);
    byte_sx = 32'(byte_s);
    half_sx = 32'(half_s);

    case (ld_type)
      LD_W:    value = word;
      LD_B:    value = byte_sx;
      LD_BU:   value = {24'd0, byte_sel};
      LD_H:    value = half_sx;
      LD_HU:   value = {16'd0, half_sel};
      default: value = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage LoongArch32 pipeline.
// - Latches the EX->MEM bus.
// - Captures synchronous data-SRAM read data, which arrives one cycle after
//   exe_stage issued the request, and holds it across WB back-pressure.
// - Aligns and extends load results.
// - Forwards the result and CSR-hazard info to decode.
// - Flags exception/ertn in MEM to exe_stage.
// - Builds the MEM->WB bus.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ws_allowin / ms_allowin    downstream / own accept handshake
//   es_to_ms_valid, _bus       EX payload
//   data_sram_rdata            SRAM read data (valid the cycle after request)
//   wb_ex, wb_ertn_flush       flushes from WB
//   mem_ex, mem_ertn_flush     exception / ertn present in MEM
//   ms_to_ds_*                 forwarding and CSR hazard info to decode
//   ms_to_ws_valid, _bus       payload to WB
//   debug_ms_pc                pc of the instruction in MEM
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       wb_ex,
  input  logic                       wb_ertn_flush,
  output logic                       mem_ex,
  output logic                       mem_ertn_flush,
  output logic [4:0]                 ms_to_ds_dest,
  output logic [31:0]                ms_to_ds_result,
  output logic                       ms_to_ds_csr_we,
  output logic [13:0]                ms_to_ds_csr_num,
  output logic                       ms_to_ds_valid,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [31:0]                debug_ms_pc
);

  es_bus_t     es_bus_p0;
  logic        ms_valid;
  logic        first_cycle;
  logic        buf_vld;
  logic [31:0] rdata_buf;

  logic        ms_ready_go;
  logic        bus_load;
  logic        flush;
  logic        advance;
  logic [31:0] load_word;
  logic [31:0] load_value;
  logic [31:0] final_result;
  ms_bus_t     ws_bus;
  logic        spare_unused;

  assign ms_ready_go = 1'b1;
  assign ms_allowin  = !ms_valid || ws_allowin;
  assign bus_load    = es_to_ms_valid && ms_allowin;
  assign flush       = wb_ex || wb_ertn_flush;
  assign advance     = ms_valid && ms_ready_go && ws_allowin;

  // ---- EX -> MEM boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (flush) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (bus_load) begin
      es_bus_p0 <= es_to_ms_bus;
    end
  end

  // first_cycle marks the only cycle in which data_sram_rdata belongs to the
  // instruction held here. It re-arms even when a new entry replaces a leaving one.
  always_ff @(posedge clk) begin
    if (reset) begin
      first_cycle <= 1'b0;
    end else begin
      first_cycle <= bus_load;
    end
  end

  // The read data is grabbed in the first cycle if WB stalls us.
  // The buffer then stands in for the SRAM until the instruction leaves.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      buf_vld <= 1'b0;
    end else if (bus_load || advance) begin
      buf_vld <= 1'b0;
    end else if (ms_valid && first_cycle && !ws_allowin) begin
      buf_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ms_valid && first_cycle && !ws_allowin && !buf_vld) begin
      rdata_buf <= data_sram_rdata;
    end
  end

  assign load_word = buf_vld ? rdata_buf : data_sram_rdata;

  mem_stage_load_extend u_load_extend (
    .ld_type (es_bus_p0.ld_type),
    .addr_lo (es_bus_p0.alu_result[1:0]),
    .word    (load_word),
    .value   (load_value)
  );

  always_comb begin
    final_result = es_bus_p0.alu_result;
    if (es_bus_p0.res_from_mem) begin
      final_result = load_value;
    end else if (es_bus_p0.src_from_csr) begin
      final_result = es_bus_p0.csr_rdata;
    end
  end

  // Combinational so exe_stage can squash its SRAM enable and divider in the
  // same cycle that the faulting instruction sits here.
  assign mem_ex         = ms_valid & es_bus_p0.ex;
  assign mem_ertn_flush = ms_valid & es_bus_p0.ertn;

  assign ms_to_ds_dest    = es_bus_p0.dest &
                            {5{ms_valid & ~es_bus_p0.inst_no_dest & es_bus_p0.gr_we}};
  assign ms_to_ds_result  = final_result;
  assign ms_to_ds_csr_we  = ms_valid & es_bus_p0.csr_we;
  assign ms_to_ds_csr_num = es_bus_p0.csr_num;
  assign ms_to_ds_valid   = ms_valid;

  // ---- MEM -> WB boundary ----
  always_comb begin
    ws_bus.gr_we        = es_bus_p0.gr_we;
    ws_bus.dest         = es_bus_p0.dest;
    ws_bus.final_result = final_result;
    ws_bus.pc           = es_bus_p0.pc;
    ws_bus.inst_no_dest = es_bus_p0.inst_no_dest;
    ws_bus.src_from_csr = es_bus_p0.src_from_csr;
    ws_bus.csr_num      = es_bus_p0.csr_num;
    ws_bus.csr_we       = es_bus_p0.csr_we;
    ws_bus.csr_wdata    = es_bus_p0.csr_wdata;
    ws_bus.csr_wmask    = es_bus_p0.csr_wmask;
    ws_bus.ex           = es_bus_p0.ex;
    ws_bus.ex_code      = es_bus_p0.ex_code;
    ws_bus.ertn         = es_bus_p0.ertn;
    ws_bus.csr_rdata    = es_bus_p0.csr_rdata;
    ws_bus.vaddr        = es_bus_p0.alu_result;
  end

  assign ms_to_ws_valid = ms_valid & ms_ready_go;
  assign ms_to_ws_bus   = ws_bus;
  assign debug_ms_pc    = es_bus_p0.pc;

  assign spare_unused = ^es_bus_p0.es_spare;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       ws_allowin;
  logic                       ms_allowin;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic [31:0]                data_sram_rdata;
  logic                       wb_ex;
  logic                       wb_ertn_flush;
  logic                       mem_ex;
  logic                       mem_ertn_flush;
  logic [4:0]                 ms_to_ds_dest;
  logic [31:0]                ms_to_ds_result;
  logic                       ms_to_ds_csr_we;
  logic [13:0]                ms_to_ds_csr_num;
  logic                       ms_to_ds_valid;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [31:0]                debug_ms_pc;

  mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .ws_allowin       (ws_allowin),
    .ms_allowin       (ms_allowin),
    .es_to_ms_valid   (es_to_ms_valid),
    .es_to_ms_bus     (es_to_ms_bus),
    .data_sram_rdata  (data_sram_rdata),
    .wb_ex            (wb_ex),
    .wb_ertn_flush    (wb_ertn_flush),
    .mem_ex           (mem_ex),
    .mem_ertn_flush   (mem_ertn_flush),
    .ms_to_ds_dest    (ms_to_ds_dest),
    .ms_to_ds_result  (ms_to_ds_result),
    .ms_to_ds_csr_we  (ms_to_ds_csr_we),
    .ms_to_ds_csr_num (ms_to_ds_csr_num),
    .ms_to_ds_valid   (ms_to_ds_valid),
    .ms_to_ws_valid   (ms_to_ws_valid),
    .ms_to_ws_bus     (ms_to_ws_bus),
    .debug_ms_pc      (debug_ms_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] pc_ctr = 32'h1c00_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] result;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [2:0]  ld_type;
    logic [31:0] vaddr;
    logic [31:0] rdata;
    logic        rfm;
    logic        src_csr;
    logic [31:0] csr_rdata;
    logic [31:0] expect_res;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic es_bus_t mk_bus(input logic rfm, input logic [2:0] ldt,
                                     input logic gr_we, input logic [4:0] dest,
                                     input logic [31:0] alu, input logic [31:0] pc,
                                     input logic no_dest, input logic src_csr,
                                     input logic [13:0] csr_num, input logic csr_we,
                                     input logic ex, input logic [14:0] ex_code,
                                     input logic ertn, input logic [31:0] csr_rdata);
    es_bus_t b;
    b.res_from_mem = rfm;
    b.ld_type      = ldt;
    b.gr_we        = gr_we;
    b.dest         = dest;
    b.alu_result   = alu;
    b.pc           = pc;
    b.inst_no_dest = no_dest;
    b.src_from_csr = src_csr;
    b.csr_num      = csr_num;
    b.csr_we       = csr_we;
    b.csr_wdata    = 32'h1234_5678;
    b.csr_wmask    = 32'hFFFF_FFFF;
    b.ex           = ex;
    b.ex_code      = ex_code;
    b.ertn         = ertn;
    b.csr_rdata    = csr_rdata;
    b.es_spare     = 2'b00;
    return b;
  endfunction

  // Drive an entry and record what WB must eventually see for it.
  task automatic enter(input es_bus_t b, input logic [31:0] exp_res);
    exp_t e;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = b;
    e.pc     = b.pc;
    e.result = exp_res;
    sb.push_back(e);
  endtask

  task automatic observe();
    ms_bus_t b;
    exp_t    e;
    if (ms_to_ws_valid && ws_allowin) begin
      b = ms_to_ws_bus;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_leave: got pc %h want no output", b.pc);
      end else begin
        e = sb.pop_front();
        check("wb_pc", b.pc, e.pc);
        check("wb_final_result", b.final_result, e.result);
      end
    end
  endtask

  // Inputs are driven at the falling edge; outputs are sampled 1 time unit later.
  task automatic cyc();
    #1;
    observe();
  endtask

  task automatic adv();
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    wb_ex          = 1'b0;
    wb_ertn_flush  = 1'b0;
  endtask

  function automatic logic [31:0] next_pc();
    pc_ctr = pc_ctr + 32'd4;
    return pc_ctr;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    es_bus_t b;
    ms_bus_t wb;

    vecs[0]  = '{LD_B,   32'h0000_1003, 32'h80FF_1234, 1'b1, 1'b0, 32'h0, 32'hFFFF_FF80};
    vecs[1]  = '{LD_BU,  32'h0000_1003, 32'h80FF_1234, 1'b1, 1'b0, 32'h0, 32'h0000_0080};
    vecs[2]  = '{LD_W,   32'h0000_2000, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0, 32'hCAFE_F00D};
    vecs[3]  = '{LD_H,   32'h0000_2002, 32'h8001_7FFF, 1'b1, 1'b0, 32'h0, 32'hFFFF_8001};
    vecs[4]  = '{LD_H,   32'h0000_2000, 32'h8001_7FFF, 1'b1, 1'b0, 32'h0, 32'h0000_7FFF};
    vecs[5]  = '{LD_HU,  32'h0000_2000, 32'h1234_F00F, 1'b1, 1'b0, 32'h0, 32'h0000_F00F};
    vecs[6]  = '{LD_B,   32'h0000_2001, 32'h0000_7F00, 1'b1, 1'b0, 32'h0, 32'h0000_007F};
    vecs[7]  = '{LD_BU,  32'h0000_2002, 32'h00A5_0000, 1'b1, 1'b0, 32'h0, 32'h0000_00A5};
    vecs[8]  = '{LD_B,   32'h0000_2000, 32'h0000_00C3, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFC3};
    vecs[9]  = '{3'b111, 32'h0000_2000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 32'h0000_0000};
    vecs[10] = '{LD_W,   32'h1357_9BDF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 32'h1357_9BDF};
    vecs[11] = '{LD_W,   32'h0000_0040, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_00B4, 32'h0000_00B4};

    reset           = 1'b1;
    ws_allowin      = 1'b1;
    es_to_ms_valid  = 1'b0;
    es_to_ms_bus    = '0;
    data_sram_rdata = 32'h0;
    wb_ex           = 1'b0;
    wb_ertn_flush   = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    #1;
    check("rst_ws_valid", 32'(ms_to_ws_valid), 32'd0);
    check("rst_ds_valid", 32'(ms_to_ds_valid), 32'd0);
    check("rst_ds_dest", 32'(ms_to_ds_dest), 32'd0);
    check("rst_mem_ex", 32'(mem_ex), 32'd0);
    check("rst_mem_ertn", 32'(mem_ertn_flush), 32'd0);
    check("rst_csr_we", 32'(ms_to_ds_csr_we), 32'd0);
    check("rst_allowin", 32'(ms_allowin), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back table: entry i is in MEM during iteration i+1 and takes that cycle's rdata.
    for (int i = 0; i <= 12; i++) begin
      data_sram_rdata = (i > 0) ? vecs[i-1].rdata : 32'h0;
      if (i < 12) begin
        b = mk_bus(vecs[i].rfm, vecs[i].ld_type, 1'b1, 5'd3, vecs[i].vaddr, next_pc(),
                   1'b0, vecs[i].src_csr, 14'd0, 1'b0, 1'b0, 15'd0, 1'b0, vecs[i].csr_rdata);
        enter(b, vecs[i].expect_res);
      end
      cyc();
      check("b2b_buf_vld", 32'(dut.buf_vld), 32'd0);
      adv();
    end

    // Stall three cycles on ld.hu while the SRAM output changes underneath.
    b = mk_bus(1'b1, LD_HU, 1'b1, 5'd4, 32'h0000_1002, next_pc(),
               1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 15'd0, 1'b0, 32'h0);
    enter(b, 32'h0000_BEEF);
    cyc();
    adv();
    ws_allowin      = 1'b0;
    data_sram_rdata = 32'hBEEF_0000;
    cyc();
    wb = ms_to_ws_bus;
    check("stall0_result", wb.final_result, 32'h0000_BEEF);
    adv();
    for (int k = 1; k < 3; k++) begin
      data_sram_rdata = 32'hDEAD_DEAD;
      cyc();
      wb = ms_to_ws_bus;
      check("stall_result", wb.final_result, 32'h0000_BEEF);
      check("stall_ws_valid", 32'(ms_to_ws_valid), 32'd1);
      adv();
    end
    ws_allowin = 1'b1;
    cyc();
    adv();

    // Exception and ertn flags in MEM
    b = mk_bus(1'b0, LD_W, 1'b0, 5'd0, 32'h0000_1001, next_pc(),
               1'b1, 1'b0, 14'd0, 1'b0, 1'b1, EXC_ALE, 1'b0, 32'h0);
    enter(b, 32'h0000_1001);
    cyc();
    check("ex_idle_mem_ex", 32'(mem_ex), 32'd0);
    adv();
    cyc();
    wb = ms_to_ws_bus;
    check("ex_mem_ex", 32'(mem_ex), 32'd1);
    check("ex_mem_ertn", 32'(mem_ertn_flush), 32'd0);
    check("ex_code", 32'(wb.ex_code), 32'(EXC_ALE));
    adv();
    b = mk_bus(1'b0, LD_W, 1'b0, 5'd0, 32'h0000_0000, next_pc(),
               1'b1, 1'b0, 14'd0, 1'b0, 1'b0, 15'd0, 1'b1, 32'h0);
    enter(b, 32'h0000_0000);
    cyc();
    adv();
    cyc();
    check("ertn_mem_ertn", 32'(mem_ertn_flush), 32'd1);
    check("ertn_mem_ex", 32'(mem_ex), 32'd0);
    adv();
    cyc();
    check("idle_mem_ex", 32'(mem_ex), 32'd0);
    check("idle_mem_ertn", 32'(mem_ertn_flush), 32'd0);
    adv();

    // wb_ex during a stall drops the instruction and its buffered data.
    b = mk_bus(1'b1, LD_W, 1'b1, 5'd9, 32'h0000_3000, next_pc(),
               1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 15'd0, 1'b0, 32'h0);
    enter(b, 32'h1111_2222);
    cyc();
    adv();
    ws_allowin      = 1'b0;
    data_sram_rdata = 32'h1111_2222;
    cyc();
    adv();
    wb_ex = 1'b1;
    sb.delete();
    cyc();
    adv();
    cyc();
    check("flush_ws_valid", 32'(ms_to_ws_valid), 32'd0);
    check("flush_ds_dest", 32'(ms_to_ds_dest), 32'd0);
    check("flush_buf_vld", 32'(dut.buf_vld), 32'd0);
    check("flush_allowin", 32'(ms_allowin), 32'd1);
    ws_allowin = 1'b1;
    b = mk_bus(1'b1, LD_W, 1'b1, 5'd9, 32'h0000_3004, next_pc(),
               1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 15'd0, 1'b0, 32'h0);
    enter(b, 32'h5555_AAAA);
    adv();
    data_sram_rdata = 32'h5555_AAAA;
    cyc();
    adv();

    // CSR-sourced result forwarded to decode
    b = mk_bus(1'b0, LD_W, 1'b1, 5'd5, 32'h0000_0777, next_pc(),
               1'b0, 1'b1, 14'h0006, 1'b1, 1'b0, 15'd0, 1'b0, 32'h0000_00B4);
    enter(b, 32'h0000_00B4);
    cyc();
    adv();
    ws_allowin = 1'b0;
    cyc();
    check("csr_ds_dest", 32'(ms_to_ds_dest), 32'd5);
    check("csr_ds_result", ms_to_ds_result, 32'h0000_00B4);
    check("csr_ds_csr_we", 32'(ms_to_ds_csr_we), 32'd1);
    check("csr_ds_csr_num", 32'(ms_to_ds_csr_num), 32'h0006);
    check("csr_ds_valid", 32'(ms_to_ds_valid), 32'd1);
    check("csr_debug_pc", debug_ms_pc, pc_ctr);
    check("csr_allowin", 32'(ms_allowin), 32'd0);
    adv();
    ws_allowin = 1'b1;
    cyc();
    adv();
    b = mk_bus(1'b0, LD_W, 1'b1, 5'd7, 32'h0000_0100, next_pc(),
               1'b1, 1'b0, 14'd0, 1'b0, 1'b0, 15'd0, 1'b0, 32'h0);
    enter(b, 32'h0000_0100);
    cyc();
    adv();
    cyc();
    check("nodest_ds_dest", 32'(ms_to_ds_dest), 32'd0);
    adv();

    // Reset asserted in the middle of a stall
    b = mk_bus(1'b1, LD_W, 1'b1, 5'd8, 32'h0000_4000, next_pc(),
               1'b1, 1'b0, 14'd3, 1'b1, 1'b1, EXC_ALE, 1'b1, 32'h0);
    enter(b, 32'h0);
    cyc();
    adv();
    ws_allowin      = 1'b0;
    data_sram_rdata = 32'h7777_8888;
    cyc();
    check("pre_rst_mem_ex", 32'(mem_ex), 32'd1);
    adv();
    reset = 1'b1;
    sb.delete();
    cyc();
    adv();
    reset = 1'b0;
    cyc();
    check("mrst_ws_valid", 32'(ms_to_ws_valid), 32'd0);
    check("mrst_ds_valid", 32'(ms_to_ds_valid), 32'd0);
    check("mrst_ds_dest", 32'(ms_to_ds_dest), 32'd0);
    check("mrst_mem_ex", 32'(mem_ex), 32'd0);
    check("mrst_mem_ertn", 32'(mem_ertn_flush), 32'd0);
    check("mrst_csr_we", 32'(ms_to_ds_csr_we), 32'd0);
    check("mrst_allowin", 32'(ms_allowin), 32'd1);
    check("mrst_buf_vld", 32'(dut.buf_vld), 32'd0);
    adv();

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
